// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetches words sequentially from memory, one
// request at a time, and queues {pc, word} pairs in a small FIFO for the
// control FSM. A branch redirect flushes the queue and restarts fetching at
// the target. Any response to a request that was already in flight when the
// redirect arrived is dropped.
module instr_prefetch_buffer #(
  parameter int N                = 16,
  parameter int A                = 16,
  parameter int DEPTH            = 4,
  parameter logic [A-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [A-1:0]           mem_addr,
  input  logic                   mem_ack,
  input  logic [N-1:0]           mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [N-1:0]           instr_data,
  output logic [A-1:0]           instr_pc,
  input  logic                   redirect_valid,
  input  logic [A-1:0]           redirect_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   fetch_pc_q, fetch_pc_d;
  logic           mem_req_q, mem_req_d;
  logic [A-1:0]   mem_addr_q, mem_addr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;

  logic [A-1:0]   pc_mem   [DEPTH];
  logic [N-1:0]   data_mem [DEPTH];

  logic           push;
  logic           pop;

  // A returned word is kept only for a live (non-discarded) request and only
  // when no redirect is flushing the queue in the same cycle.
  assign push        = (state_q == FETCH) && mem_ack && !redirect_valid;
  // The head is hidden during a redirect so the FSM never consumes a stale entry.
  assign instr_valid = (count_q != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign fifo_count  = count_q;
  assign instr_pc    = pc_mem[rd_ptr_q];
  assign instr_data  = data_mem[rd_ptr_q];

  // Fetch FSM next state: one outstanding request, request line registered.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if ((count_q < CW'(DEPTH)) && !redirect_valid) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!redirect_valid) begin
            fetch_pc_d = fetch_pc_q + A'(1);
          end
        end else if (redirect_valid) begin
          // Request stays on the bus until acked; its data will be dropped.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end
  end

  // FIFO pointer/occupancy next state; a redirect empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage: written on push, contents qualified by count so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= mem_addr_q;
      data_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer: a simple memory responder with
// random latency, random ready/redirect traffic, and a queue-based reference
// model of the fetched instruction stream.
module tb_instr_prefetch_buffer;

  localparam int N     = 16;
  localparam int A     = 16;
  localparam int DEPTH = 4;
  localparam logic [A-1:0] RESET_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic [A-1:0]  mem_addr;
  logic          mem_ack;
  logic [N-1:0]  mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [N-1:0]  instr_data;
  logic [A-1:0]  instr_pc;
  logic          redirect_valid;
  logic [A-1:0]  redirect_pc;
  logic [$clog2(DEPTH):0] fifo_count;

  instr_prefetch_buffer #(
    .N(N), .A(A), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Stimulus knobs
  int ready_pct   = 100;
  int redir_pct   = 0;
  int max_lat     = 0;
  bit force_redir = 0;
  logic [A-1:0] force_pc = '0;
  bit stale_ack   = 0;
  int ack_wait    = -1;

  // Reference model: queue of {pc, word} expected in the FIFO
  logic [31:0]  exp_q[$];
  bit           exp_req;
  bit           req_live;
  logic [A-1:0] req_addr;
  logic [A-1:0] nxt_fetch;

  // Wrap observation
  bit           have_prev;
  logic [A-1:0] prev_pc;
  bit           seen_wrap;

  function automatic logic [N-1:0] memf(input logic [A-1:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_req   = 0;
    req_live  = 0;
    req_addr  = RESET_PC;
    nxt_fetch = RESET_PC;
    have_prev = 0;
    ack_wait  = -1;
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_mem_req"},     32'(mem_req), 32'd0);
    check_eq({tag, "_mem_addr"},    32'(mem_addr), 32'(RESET_PC));
    check_eq({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_fifo_count"},  32'(fifo_count), 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    int sz;
    bit exp_valid;
    bit exp_req_n;
    mem_ack   = 1'b0;
    mem_rdata = N'($urandom);
    if (mem_req) begin
      if (ack_wait < 0) ack_wait = int'($urandom_range(0, max_lat));
      if (ack_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memf(mem_addr);
        ack_wait  = -1;
      end else begin
        ack_wait--;
      end
    end else begin
      ack_wait = -1;
    end
    if (stale_ack) begin
      mem_ack   = 1'b1;
      stale_ack = 0;
    end
    instr_ready    = ($urandom_range(0, 99) < ready_pct);
    redirect_valid = force_redir || ($urandom_range(0, 99) < redir_pct);
    if (force_redir)
      redirect_pc = force_pc;
    else if ($urandom_range(0, 1) == 1)
      redirect_pc = A'($urandom);
    else
      redirect_pc = 16'hFFFC + A'($urandom_range(0, 3));
    force_redir = 0;
    #1;

    sz        = exp_q.size();
    exp_valid = (sz != 0) && !redirect_valid;
    check_eq("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check_eq("mem_addr", 32'(mem_addr), 32'(req_addr));
    check_eq("fifo_count", 32'(fifo_count), 32'(sz));
    check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("instr_pc", 32'(instr_pc), 32'(exp_q[0][31:16]));
      check_eq("instr_data", 32'(instr_data), 32'(exp_q[0][15:0]));
    end
    if (instr_valid && instr_ready) begin
      if (have_prev && prev_pc == 16'hFFFF && instr_pc == 16'h0000) seen_wrap = 1;
      prev_pc   = instr_pc;
      have_prev = 1;
    end

    if (exp_valid && instr_ready) void'(exp_q.pop_front());
    if (exp_req) begin
      if (mem_ack && req_live && !redirect_valid) begin
        exp_q.push_back({req_addr, memf(req_addr)});
        nxt_fetch = req_addr + 16'd1;
      end
      exp_req_n = !mem_ack;
    end else begin
      exp_req_n = (sz < DEPTH) && !redirect_valid;
      if (exp_req_n) begin
        req_addr = nxt_fetch;
        req_live = 1;
      end
    end
    if (redirect_valid) begin
      exp_q.delete();
      nxt_fetch = redirect_pc;
      req_live  = 0;
      have_prev = 0;
    end
    exp_req = exp_req_n;

    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst            = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    seen_wrap      = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;

    // Back-to-back fetch with single-cycle memory and an always-ready consumer
    ready_pct = 100; redir_pct = 0; max_lat = 0;
    repeat (20) step();

    // Consumer stalls: queue fills to DEPTH and fetching stops
    ready_pct = 0; max_lat = 2;
    repeat (30) step();
    check_eq("full_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("full_no_req", 32'(mem_req), 32'd0);

    // Consumer resumes: in-order drain and fetching continues
    ready_pct = 100;
    repeat (20) step();

    // Redirect to the top of the address space: PC wraps to zero
    force_redir = 1; force_pc = 16'hFFFF; max_lat = 1;
    repeat (25) step();
    check_eq("wrap_seen", 32'(seen_wrap), 32'd1);

    // Reset in the middle of an outstanding request, then a stale ack
    max_lat = 3; ready_pct = 50;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (mem_req) found = 1;
    end
    check_eq("found_fetch", 32'(found), 32'd1);
    rst            = 1'b0;
    mem_ack        = 1'b0;
    redirect_valid = 1'b0;
    #1;
    reset_checks("mid_reset");
    @(posedge clk);
    #1;
    reset_checks("held_reset");
    rst = 1'b1;
    model_reset();
    stale_ack = 1;
    repeat (20) step();

    // Mixed random traffic with redirects and variable latency
    ready_pct = 60; redir_pct = 6; max_lat = 3;
    repeat (2000) step();
    ready_pct = 90; redir_pct = 2; max_lat = 0;
    repeat (500) step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
